// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write scheduler.
package regfile_pkg;

    localparam int unsigned REG_COUNT   = 32;
    localparam int unsigned INDEX_W     = 5;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned FILL_CYCLES = REG_COUNT / 2;
    localparam int unsigned FILL_W      = $clog2(FILL_CYCLES);
    localparam int unsigned STAT_W      = 16;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    // One register-file write port payload.
    typedef struct packed {
        logic               en;
        logic [INDEX_W-1:0] index;
        logic [DATA_W-1:0]  data;
    } wr_port_t;

endpackage

// File: rtl/regfile_write_scheduler_rr_pick.sv
// Round-robin picker: first set bit of mask at or after start, wrapping mod N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] start,
    output logic          found,
    output logic [PW-1:0] pick
);

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && mask[PW'((32'(start) + i) % N)]) begin
                found = 1'b1;
                pick  = PW'((32'(start) + i) % N);
            end
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Two-port register-file write scheduler: zero-fill after reset, then round-robin dual grant.
// Optional conflict statistics counter enabled by WRSCHED_STATS_EN.
module regfile_write_scheduler
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       clock,
    input  logic                       clear_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*INDEX_W-1:0] req_index,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       write1,
    output logic                       write2,
    output logic [INDEX_W-1:0]         write_index1,
    output logic [INDEX_W-1:0]         write_index2,
    output logic [DATA_W-1:0]          write_data1,
    output logic [DATA_W-1:0]          write_data2,
`ifdef WRSCHED_STATS_EN
    output logic [STAT_W-1:0]          conflict_count,
`endif
    output logic                       init_done
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    state_t             state, state_next;
    logic [FILL_W-1:0]  fill_k, fill_k_next;
    logic [PW-1:0]      ptr, ptr_next;
    wr_port_t           port1_q, port2_q, port1_next, port2_next;

    logic               found_a, found_b;
    logic [PW-1:0]      pick_a, pick_b, start_b;
    logic [INDEX_W-1:0] index_a, index_b;
    logic [DATA_W-1:0]  data_a, data_b;
    logic [NUM_REQ-1:0] same_a, mask_b;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_a (
        .mask  (req_valid),
        .start (ptr),
        .found (found_a),
        .pick  (pick_a)
    );

    always_comb begin
        index_a = '0;
        data_a  = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (PW'(r) == pick_a) begin
                index_a = req_index[r*INDEX_W +: INDEX_W];
                data_a  = req_data[r*DATA_W +: DATA_W];
            end
        end
    end

    // Second scan starts just after A; requesters targeting A's index must wait.
    always_comb begin
        same_a = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            same_a[r] = req_valid[r] && (req_index[r*INDEX_W +: INDEX_W] == index_a)
                        && (PW'(r) != pick_a);
        end
        mask_b  = req_valid & ~same_a & ~(NUM_REQ'(1) << pick_a);
        start_b = (pick_a == PW'(NUM_REQ - 1)) ? '0 : pick_a + PW'(1);
    end

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_b (
        .mask  (mask_b),
        .start (start_b),
        .found (found_b),
        .pick  (pick_b)
    );

    always_comb begin
        index_b = '0;
        data_b  = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (PW'(r) == pick_b) begin
                index_b = req_index[r*INDEX_W +: INDEX_W];
                data_b  = req_data[r*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state  <= INIT;
            fill_k <= '0;
            ptr    <= '0;
        end else begin
            state  <= state_next;
            fill_k <= fill_k_next;
            ptr    <= ptr_next;
        end
    end

    always_comb begin
        state_next  = state;
        fill_k_next = fill_k;
        ptr_next    = ptr;
        port1_next  = '0;
        port2_next  = '0;
        req_ready   = '0;
        case (state)
            INIT: begin
                port1_next  = '{en: 1'b1, index: {fill_k, 1'b0}, data: '0};
                port2_next  = '{en: 1'b1, index: {fill_k, 1'b1}, data: '0};
                fill_k_next = fill_k + FILL_W'(1);
                if (fill_k == FILL_W'(FILL_CYCLES - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (found_a) begin
                    req_ready[pick_a] = 1'b1;
                    port1_next        = '{en: 1'b1, index: index_a, data: data_a};
                    ptr_next          = (pick_a == PW'(NUM_REQ - 1)) ? '0 : pick_a + PW'(1);
                end
                if (found_b) begin
                    req_ready[pick_b] = 1'b1;
                    port2_next        = '{en: 1'b1, index: index_b, data: data_b};
                    ptr_next          = (pick_b == PW'(NUM_REQ - 1)) ? '0 : pick_b + PW'(1);
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            port1_q   <= '0;
            port2_q   <= '0;
            init_done <= 1'b0;
        end else begin
            port1_q   <= port1_next;
            port2_q   <= port2_next;
            init_done <= (state_next == RUN);
        end
    end

    assign write1       = port1_q.en;
    assign write_index1 = port1_q.index;
    assign write_data1  = port1_q.data;
    assign write2       = port2_q.en;
    assign write_index2 = port2_q.index;
    assign write_data2  = port2_q.data;

`ifdef WRSCHED_STATS_EN
    logic              conflict;
    logic [STAT_W-1:0] conflict_q;

    assign conflict = found_a && (|same_a);

    // Saturating count of RUN cycles where a same-index requester was held back.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            conflict_q <= '0;
        end else if ((state == RUN) && conflict && (conflict_q != '1)) begin
            conflict_q <= conflict_q + STAT_W'(1);
        end
    end

    assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: fill sequence, directed table, reset abort, random vs model.
module tb_regfile_write_scheduler;

    localparam int NUM_REQ = 4;

    logic                  clock;
    logic                  clear_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*5-1:0]  req_index;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  write1, write2;
    logic [4:0]            write_index1, write_index2;
    logic [31:0]           write_data1, write_data2;
    logic                  init_done;
`ifdef WRSCHED_STATS_EN
    logic [15:0]           conflict_count;
`endif

    logic [3:0]  valid;
    logic [4:0]  idx [NUM_REQ];
    logic [31:0] dat [NUM_REQ];

    int checks = 0;
    int errors = 0;

    regfile_write_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .clock          (clock),
        .clear_n        (clear_n),
        .req_valid      (req_valid),
        .req_index      (req_index),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .write1         (write1),
        .write2         (write2),
        .write_index1   (write_index1),
        .write_index2   (write_index2),
        .write_data1    (write_data1),
        .write_data2    (write_data2),
`ifdef WRSCHED_STATS_EN
        .conflict_count (conflict_count),
`endif
        .init_done      (init_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        req_valid = valid;
        req_index = '0;
        req_data  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_index[r*5 +: 5]   = idx[r];
            req_data[r*32 +: 32]  = dat[r];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]   valid;
        logic [19:0]  idx;
        logic [127:0] data;
        logic [3:0]   rdy;
        logic [37:0]  p1;
        logic [37:0]  p2;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input int i0, input int i1, input int i2,
                                input int i3, input int d0, input int d1, input int d2,
                                input int d3, input logic [3:0] r, input int a_i, input int a_d,
                                input bit b_en, input int b_i, input int b_d);
        vec_t t;
        t.valid = v;
        t.idx   = {5'(i3), 5'(i2), 5'(i1), 5'(i0)};
        t.data  = {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
        t.rdy   = r;
        t.p1    = (r != 4'b0) ? {1'b1, 5'(a_i), 32'(a_d)} : 38'd0;
        t.p2    = b_en ? {1'b1, 5'(b_i), 32'(b_d)} : 38'd0;
        return t;
    endfunction

    // Reference arbitration computed from the scan rules on the current requests.
    int m_p, m_a, m_b, m_conf_cnt;
    bit m_fa, m_fb, m_conf;

    task automatic model_arb();
        m_fa   = 0;
        m_fb   = 0;
        m_conf = 0;
        m_a    = 0;
        m_b    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int r;
            r = (m_p + k) % NUM_REQ;
            if (valid[r]) begin
                if (!m_fa) begin
                    m_fa = 1;
                    m_a  = r;
                end else if (idx[r] == idx[m_a]) begin
                    m_conf = 1;
                end else if (!m_fb) begin
                    m_fb = 1;
                    m_b  = r;
                end
            end
        end
    endtask

    task automatic init_check(input logic [3:0] ready_at_16);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clock); #1;
            check("init_port1", {write1, write_index1, write_data1}, {1'b1, 5'(2*(c-1)), 32'd0});
            check("init_port2", {write2, write_index2, write_data2}, {1'b1, 5'(2*c-1), 32'd0});
            check("init_done", init_done, (c == 16));
            check("init_ready", req_ready, (c == 16) ? ready_at_16 : 4'b0);
        end
    endtask

    vec_t       tbl [13];
    vec_t       vt;
    logic [3:0] exp_rdy;

    initial begin
        tbl[0]  = mk(4'b0011,  5,  5,  0,  0,   11,   22,    0,    0, 4'b0001,  5,   11, 0,  0,    0);
        tbl[1]  = mk(4'b0010,  0,  5,  0,  0,    0,   22,    0,    0, 4'b0010,  5,   22, 0,  0,    0);
        tbl[2]  = mk(4'b1111, 10, 11, 12, 13, 1000, 1001, 1002, 1003, 4'b1100, 12, 1002, 1, 13, 1003);
        tbl[3]  = mk(4'b1111, 10, 11, 12, 13, 1000, 1001, 1002, 1003, 4'b0011, 10, 1000, 1, 11, 1001);
        tbl[4]  = mk(4'b1111, 10, 11, 12, 13, 1000, 1001, 1002, 1003, 4'b1100, 12, 1002, 1, 13, 1003);
        tbl[5]  = mk(4'b0011, 10, 11,  0,  0, 1000, 1001,    0,    0, 4'b0011, 10, 1000, 1, 11, 1001);
        tbl[6]  = mk(4'b1111,  9,  9,  9,  9, 2000, 2001, 2002, 2003, 4'b0100,  9, 2002, 0,  0,    0);
        tbl[7]  = mk(4'b1111,  9,  9,  9,  9, 2000, 2001, 2002, 2003, 4'b1000,  9, 2003, 0,  0,    0);
        tbl[8]  = mk(4'b1111,  9,  9,  9,  9, 2000, 2001, 2002, 2003, 4'b0001,  9, 2000, 0,  0,    0);
        tbl[9]  = mk(4'b1111,  9,  9,  9,  9, 2000, 2001, 2002, 2003, 4'b0010,  9, 2001, 0,  0,    0);
        tbl[10] = mk(4'b0000,  0,  0,  0,  0,    0,    0,    0,    0, 4'b0000,  0,    0, 0,  0,    0);
        tbl[11] = mk(4'b1010,  0,  4,  0,  4,    0,    7,    0,    8, 4'b1000,  4,    8, 0,  0,    0);
        tbl[12] = mk(4'b0010,  0,  4,  0,  0,    0,    7,    0,    0, 4'b0010,  4,    7, 0,  0,    0);

        // Reset with requests already pending: nothing may be granted.
        clear_n = 1'b0;
        valid   = 4'b0101;
        for (int r = 0; r < NUM_REQ; r++) begin
            idx[r] = '0;
            dat[r] = '0;
        end
        idx[0] = 5'd3; dat[0] = 32'd100;
        idx[2] = 5'd7; dat[2] = 32'd200;
        repeat (2) @(negedge clock);
        check("rst_port1", {write1, write_index1, write_data1}, 38'd0);
        check("rst_port2", {write2, write_index2, write_data2}, 38'd0);
        check("rst_ready", req_ready, 4'b0);
        check("rst_init_done", init_done, 1'b0);
`ifdef WRSCHED_STATS_EN
        check("rst_conflict", conflict_count, 16'd0);
`endif
        clear_n = 1'b1;
        init_check(4'b0101);
        @(posedge clock); #1;
        check("first_port1", {write1, write_index1, write_data1}, {1'b1, 5'd3, 32'd100});
        check("first_port2", {write2, write_index2, write_data2}, {1'b1, 5'd7, 32'd200});

        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            vt    = tbl[i];
            valid = vt.valid;
            for (int r = 0; r < NUM_REQ; r++) begin
                idx[r] = vt.idx[r*5 +: 5];
                dat[r] = vt.data[r*32 +: 32];
            end
            #1;
            check("tbl_ready", req_ready, vt.rdy);
            @(posedge clock); #1;
            check("tbl_port1", {write1, write_index1, write_data1}, vt.p1);
            check("tbl_port2", {write2, write_index2, write_data2}, vt.p2);
        end
`ifdef WRSCHED_STATS_EN
        check("tbl_conflict", conflict_count, 16'd6);
`endif

        // Reset lands right after a grant registers: write must vanish and fill restart.
        @(negedge clock);
        valid  = 4'b0001;
        idx[0] = 5'd20;
        dat[0] = 32'd55;
        #1;
        check("abort_ready", req_ready, 4'b0001);
        @(posedge clock); #1;
        check("abort_pre_port1", {write1, write_index1, write_data1}, {1'b1, 5'd20, 32'd55});
        clear_n = 1'b0;
        #1;
        check("abort_port1", {write1, write_index1, write_data1}, 38'd0);
        check("abort_port2", {write2, write_index2, write_data2}, 38'd0);
        check("abort_ready_rst", req_ready, 4'b0);
        check("abort_init_done", init_done, 1'b0);
        @(negedge clock);
        valid   = 4'b0000;
        @(negedge clock);
        clear_n = 1'b1;
        init_check(4'b0000);

        // Random traffic against the reference model.
        m_p        = 0;
        m_fa       = 0;
        m_fb       = 0;
        m_conf_cnt = 0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clock);
            if (m_fa) valid[m_a] = 1'b0;
            if (m_fb) valid[m_b] = 1'b0;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!valid[r] && ($urandom_range(0, 1) == 1)) begin
                    valid[r] = 1'b1;
                    idx[r]   = 5'($urandom_range(0, 7));
                    dat[r]   = $urandom;
                end
            end
            model_arb();
            exp_rdy = 4'b0;
            if (m_fa) exp_rdy[m_a] = 1'b1;
            if (m_fb) exp_rdy[m_b] = 1'b1;
            #1;
            check("rand_ready", req_ready, exp_rdy);
            @(posedge clock); #1;
            check("rand_port1", {write1, write_index1, write_data1},
                  m_fa ? {1'b1, idx[m_a], dat[m_a]} : 38'd0);
            check("rand_port2", {write2, write_index2, write_data2},
                  m_fb ? {1'b1, idx[m_b], dat[m_b]} : 38'd0);
            if (m_conf) m_conf_cnt++;
            if (m_fb) m_p = (m_b + 1) % NUM_REQ;
            else if (m_fa) m_p = (m_a + 1) % NUM_REQ;
        end
`ifdef WRSCHED_STATS_EN
        check("rand_conflict", conflict_count, 64'(m_conf_cnt));
`endif
        @(negedge clock);
        valid = 4'b0000;

`ifdef WRSCHED_STATS_EN
        // Two requesters hammering one index conflict every cycle until saturation.
        @(negedge clock);
        valid  = 4'b0011;
        idx[0] = 5'd1;
        idx[1] = 5'd1;
        repeat (70000) @(posedge clock);
        #1;
        check("sat_conflict", conflict_count, 16'hFFFF);
        @(negedge clock);
        valid = 4'b0000;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Arbitrates write requests from NUM_REQ independent requesters onto the two write ports of the 32x32 register file, granting up to two non-conflicting writes per cycle with round-robin fairness. After every reset it first sequences a zero-fill of all 32 registers through both ports, then enters normal arbitration. It sits directly in front of the register file's write side; read ports are untouched.

## Interface
- NUM_REQ, 4, number of requesters (legal 2..8)
- clock  in  1  single clock; all state updates on posedge
- clear_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_index  in  NUM_REQ*5  packed target register index, requester r at [5r+4:5r]
- req_data  in  NUM_REQ*32  packed write data, requester r at [32r+31:32r]
- req_ready  out  NUM_REQ  grant; transfer occurs when req_valid[r] & req_ready[r]
- write1, write2  out  1  write-port enables to register file
- write_index1, write_index2  out  5  write-port indices
- write_data1, write_data2  out  32  write-port data
- init_done  out  1  high once zero-fill complete
- conflict_count  out  16  saturating same-index conflict counter (only with WRSCHED_STATS_EN)

## Operation
- States: INIT, RUN. Reset enters INIT with fill counter k=0.
- INIT: each cycle drives write1=1/index 2k/data 0 and write2=1/index 2k+1/data 0; k increments; after k=15 go to RUN. req_ready=0 throughout. init_done rises on entry to RUN and stays high.
- RUN arbitration (combinational, each cycle): scan requesters starting at round-robin pointer p, wrapping mod NUM_REQ.
  - First valid requester = grant A, routed to port 1.
  - Continue scan; first later valid requester whose index differs from A's = grant B, routed to port 2. Valid requesters with index equal to A's are skipped (conflict) and wait.
  - req_ready asserted only for A and B; never for a non-valid requester.
  - Pointer update on posedge: if any grant, p = (last granted requester + 1) mod NUM_REQ; else unchanged.
- Requesters hold valid/index/data stable until granted; dropping valid before grant is illegal.
- No write is ever dropped or merged; two same-index requests complete in separate cycles, earlier in scan order first.

## Timing
- Write outputs registered: a handshake in cycle n produces write pulse on the matching port in cycle n+1, high exactly one cycle, with index/data of the granted request. Outputs stable across the following negedge.
- Port with no grant: enable 0, index and data driven 0.
- Reset values: write1=write2=0, indices 0, data 0, req_ready 0, init_done 0, p=0, k=0, conflict_count 0.
- INIT lasts exactly 16 cycles after clear_n deasserts; first possible grant in cycle 16, first RUN write in cycle 17.
- Throughput: 2 writes/cycle when two or more distinct-index requests are valid.
- clear_n asserted mid-operation (INIT or RUN): outputs return to reset values immediately; in-flight registered writes are discarded; fill restarts from k=0.
- All requesters valid, all same index: one grant per cycle, rotating fairly; max wait NUM_REQ-1 cycles.

## Configuration
- WRSCHED_STATS_EN defined: conflict_count port present; increments by 1 on each RUN cycle with at least one conflict skip; saturates at 16'hFFFF; cleared only by reset.
- Undefined: port and counter logic absent; arbitration identical.

## Structure
- Shared package regfile_pkg: REG_COUNT=32, INDEX_W=5, DATA_W=32, FILL_CYCLES=16, state enum {INIT, RUN}.
- One sub-module: rr_pick — given request mask and start pointer, returns first-set index and found flag; instantiated twice (second with A and conflicting requesters masked out).

## Test plan
- Reset release -> 16 cycles of paired writes indices (0,1)..(30,31) data 0, req_ready all 0, init_done high in cycle 16.
- RUN, req 0 index 3 data 100, req 2 index 7 data 200 -> both ready same cycle; next cycle write1 idx 3/100, write2 idx 7/200; p becomes 3.
- RUN, req 0 and req 1 both index 5 (data 11, 22) -> cycle 1 grants req 0 only (port 1, 11), cycle 2 grants req 1 (port 1, 22); conflict_count=1 with WRSCHED_STATS_EN.
- All 4 requesters continuously valid, distinct indices -> grant pairs (0,1),(2,3),(0,1)...; 8 writes in 4 cycles.
- clear_n pulsed low during RUN with grant outstanding -> write enables 0 immediately, no write for that grant, INIT fill restarts from indices 0/1.
- 70000 conflict cycles with WRSCHED_STATS_EN -> conflict_count holds at 65535.
